// File: rtl/cam_pixel_capture_crop.sv
// -----------------------------------------------------------------------------
// cam_pixel_capture_crop
//
// Captures pixels from an OV7670-style parallel camera bus entirely in the
// clk_100 domain. The camera pclk/href/vsync are oversampled as data through
// two-flop samplers. Bytes are assembled into PIX_BYTES-wide pixels (first
// byte in the MSBs). A compile-time crop window with 2**DEC_LOG2 decimation
// selects the pixels that become linear-addressed RAM writes.
// Supports snapshot (arm, cont=0) and continuous (arm, cont=1) capture, abort,
// and short-frame error reporting.
//
// Ports:
//   clk_100      system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cmos_pclk    camera pixel clock (sampled as data)
//   cmos_href    camera line valid
//   cmos_vsync   camera frame sync, high = blanking
//   cmos_db      camera data byte
//   arm          pulse, start capture (accepted only in IDLE)
//   cont         continuous mode, latched when arm is accepted
//   abort        pulse, return to IDLE immediately
//   wr_en        RAM write strobe
//   wr_addr      RAM write address (0 .. OUT_PIX-1)
//   wr_data      assembled pixel
//   busy         high outside IDLE
//   frame_done   one-cycle pulse, frame complete
//   frame_err    one-cycle pulse, frame cut short by vsync
//   frame_cnt    completed frame count, wraps
//
// Optional feature macro CAPTURE_STATS_EN: adds last_lines / last_pix outputs
// holding the final row count and write count of the last finished frame.
// -----------------------------------------------------------------------------
module cam_pixel_capture_crop #(
    parameter int DATA_W    = 8,
    parameter int PIX_BYTES = 2,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int CROP_X0   = 0,
    parameter int CROP_W    = 640,
    parameter int CROP_Y0   = 0,
    parameter int CROP_H    = 480,
    parameter int DEC_LOG2  = 0,
    parameter int ADDR_W    = 19
) (
    input  logic                          clk_100,
    input  logic                          rst_n,
    input  logic                          cmos_pclk,
    input  logic                          cmos_href,
    input  logic                          cmos_vsync,
    input  logic [DATA_W-1:0]             cmos_db,
    input  logic                          arm,
    input  logic                          cont,
    input  logic                          abort,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [DATA_W*PIX_BYTES-1:0]   wr_data,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          frame_err,
    output logic [7:0]                    frame_cnt
`ifdef CAPTURE_STATS_EN
    ,
    output logic [9:0]                    last_lines,
    output logic [ADDR_W-1:0]             last_pix
`endif
);

    localparam int PIX_W    = DATA_W * PIX_BYTES;
    localparam int OUT_PIX  = (CROP_W >> DEC_LOG2) * (CROP_H >> DEC_LOG2);
    localparam int COL_W    = $clog2(H_ACTIVE + 1);
    localparam int ROW_W    = $clog2(V_ACTIVE + 1);
    localparam int PH_W     = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
    localparam int DEC_MASK = (1 << DEC_LOG2) - 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_PIX - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

    state_t             state_q, state_d;
    logic               pclk_p1, pclk_p2, href_p1, href_p2, vsync_p1, vsync_p2;
    logic               pclk_rise, line_vld, href_fall, frame_start, vs_high;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [PH_W-1:0]    byte_ph;
    logic               cont_q;
    logic [PIX_W-1:0]   pix_sr, pix_next;
    logic               byte_take, pix_done, last_wr;
    logic               start_d, err_d, latch_cont, wr_en_d;

    function automatic int sat_inc(input int v, input int lim);
        return (v >= lim) ? v : v + 1;
    endfunction

    // Crop window plus decimation phase test for a completed pixel.
    function automatic logic in_window(input int c, input int r);
        return (c >= CROP_X0) && (c < CROP_X0 + CROP_W) &&
               (r >= CROP_Y0) && (r < CROP_Y0 + CROP_H) &&
               (((c - CROP_X0) & DEC_MASK) == 0) &&
               (((r - CROP_Y0) & DEC_MASK) == 0);
    endfunction

    // ---- sampler stage: p1 / p2 copies of the camera control lines ----
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            pclk_p1  <= 1'b0;
            pclk_p2  <= 1'b0;
            href_p1  <= 1'b0;
            href_p2  <= 1'b0;
            vsync_p1 <= 1'b0;
            vsync_p2 <= 1'b0;
        end else begin
            pclk_p1  <= cmos_pclk;
            pclk_p2  <= pclk_p1;
            href_p1  <= cmos_href;
            href_p2  <= href_p1;
            vsync_p1 <= cmos_vsync;
            vsync_p2 <= vsync_p1;
        end
    end

    assign pclk_rise   = pclk_p1 & ~pclk_p2;
    assign line_vld    = href_p1 & href_p2;
    assign href_fall   = href_p2 & ~href_p1;
    assign frame_start = ~vsync_p1 & vsync_p2;
    assign vs_high     = vsync_p1 & vsync_p2;

    // cmos_db is taken raw: it is stable around the sampled pclk rise.
    assign byte_take = (state_q == CAPTURE) && pclk_rise && line_vld;
    assign pix_done  = byte_take && (int'(byte_ph) == PIX_BYTES - 1);
    assign pix_next  = (pix_sr << DATA_W) | PIX_W'(cmos_db);
    assign last_wr   = wr_en && (wr_addr == LAST_ADDR);

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        err_d      = 1'b0;
        latch_cont = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d    = WAIT_VS;
                        latch_cont = 1'b1;
                    end
                end
                WAIT_VS: begin
                    if (frame_start) begin
                        state_d = CAPTURE;
                        start_d = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (last_wr) begin
                        state_d = DONE;
                    end else if (vs_high) begin
                        err_d   = 1'b1;
                        state_d = cont_q ? WAIT_VS : IDLE;
                    end
                end
                DONE:    state_d = cont_q ? WAIT_VS : IDLE;
                default: state_d = IDLE;
            endcase
        end
        // Writes only while staying in CAPTURE: this drops a pixel that
        // completes alongside abort, vsync or the final write.
        wr_en_d = pix_done && (state_d == CAPTURE) && in_window(int'(col), int'(row));
    end

    // ---- capture stage: counters, address, write register ----
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cont_q    <= 1'b0;
            col       <= '0;
            row       <= '0;
            byte_ph   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            wr_en     <= wr_en_d;
            frame_err <= err_d;
            if (latch_cont) cont_q <= cont;
            if (wr_en_d) wr_data <= pix_next;
            if (state_q == DONE) frame_cnt <= frame_cnt + 8'd1;

            if (start_d) begin
                col     <= '0;
                row     <= '0;
                byte_ph <= '0;
                wr_addr <= '0;
            end else begin
                if (wr_en && !last_wr) wr_addr <= wr_addr + 1'b1;
                if (state_q == CAPTURE) begin
                    if (href_fall && (col != '0)) begin
                        col     <= '0;
                        row     <= ROW_W'(sat_inc(int'(row), V_ACTIVE));
                        byte_ph <= '0;
                    end else if (pix_done) begin
                        col     <= COL_W'(sat_inc(int'(col), H_ACTIVE));
                        byte_ph <= '0;
                    end else if (byte_take) begin
                        byte_ph <= byte_ph + 1'b1;
                    end
                end
            end
        end
    end

    // Byte assembly register; pure data, no reset needed.
    always_ff @(posedge clk_100) begin
        if (byte_take) pix_sr <= pix_next;
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

`ifdef CAPTURE_STATS_EN
    // On DONE the frame ends inside line `row`, so it counts as one more line.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            last_lines <= '0;
            last_pix   <= '0;
        end else if (state_q == DONE) begin
            last_lines <= 10'(int'(row) + 1);
            last_pix   <= ADDR_W'(OUT_PIX);
        end else if (err_d) begin
            last_lines <= 10'(row);
            last_pix   <= wr_addr + ADDR_W'(wr_en);
        end
    end
`endif

endmodule

// File: tb/tb_cam_pixel_capture_crop.sv
module tb_cam_pixel_capture_crop;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int X0 = 2;
    localparam int CW = 4;
    localparam int Y0 = 1;
    localparam int CH = 4;

    logic clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    logic       rst_n = 1'b0;
    logic       cmos_pclk = 1'b0, cmos_href = 1'b0, cmos_vsync = 1'b1;
    logic [7:0] cmos_db = 8'h00;
    logic       arm_a = 1'b0, cont_a = 1'b0, abort_a = 1'b0;
    logic       arm_b = 1'b0, cont_b = 1'b0, abort_b = 1'b0;

    logic        wr_en_a, busy_a, frame_done_a, frame_err_a;
    logic [3:0]  wr_addr_a;
    logic [15:0] wr_data_a;
    logic [7:0]  frame_cnt_a;
    logic        wr_en_b, busy_b, frame_done_b, frame_err_b;
    logic [4:0]  wr_addr_b;
    logic [7:0]  wr_data_b;
    logic [7:0]  frame_cnt_b;

    cam_pixel_capture_crop #(
        .DATA_W(8), .PIX_BYTES(2), .H_ACTIVE(H), .V_ACTIVE(V),
        .CROP_X0(X0), .CROP_W(CW), .CROP_Y0(Y0), .CROP_H(CH),
        .DEC_LOG2(1), .ADDR_W(4)
    ) dut_a (
        .clk_100(clk_100), .rst_n(rst_n), .cmos_pclk(cmos_pclk), .cmos_href(cmos_href),
        .cmos_vsync(cmos_vsync), .cmos_db(cmos_db), .arm(arm_a), .cont(cont_a),
        .abort(abort_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .frame_done(frame_done_a), .frame_err(frame_err_a),
        .frame_cnt(frame_cnt_a)
    );

    cam_pixel_capture_crop #(
        .DATA_W(8), .PIX_BYTES(1), .H_ACTIVE(H), .V_ACTIVE(V),
        .CROP_X0(X0), .CROP_W(CW), .CROP_Y0(Y0), .CROP_H(CH),
        .DEC_LOG2(0), .ADDR_W(5)
    ) dut_b (
        .clk_100(clk_100), .rst_n(rst_n), .cmos_pclk(cmos_pclk), .cmos_href(cmos_href),
        .cmos_vsync(cmos_vsync), .cmos_db(cmos_db), .arm(arm_b), .cont(cont_b),
        .abort(abort_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .frame_done(frame_done_b), .frame_err(frame_err_b),
        .frame_cnt(frame_cnt_b)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];
    int  log_a[$];
    int  log_b[$];
    int  pix0 [0:V-1][0:H-1];
    int  pix1 [0:V-1][0:H-1];
    int  n_checks = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  n_done_a = 0, n_errp_a = 0, n_done_b = 0, n_errp_b = 0;
    int  lastwr_cyc_a = 0, done_cyc_a = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Camera content: pattern {row,col} (or col only for 1-byte pixels) or random.
    task automatic fill_pattern(input int bpp);
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++) begin
                pix0[r][c] = (bpp == 2) ? r : c;
                pix1[r][c] = c;
            end
    endtask

    task automatic fill_random();
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++) begin
                pix0[r][c] = int'($urandom_range(0, 255));
                pix1[r][c] = int'($urandom_range(0, 255));
            end
    endtask

    // Reference: walk the frame in raster order, keep pixels inside the crop
    // window on the decimation grid, number them 0.. and stop at outpix.
    task automatic model_frame(input int nrows, input int bpp, input int dec,
                               input int outpix, input bit to_b);
        int  n = 0;
        wr_t e;
        for (int r = 0; r < nrows; r++)
            for (int c = 0; c < H; c++)
                if (r >= Y0 && r < Y0 + CH && c >= X0 && c < X0 + CW &&
                    (c - X0) % dec == 0 && (r - Y0) % dec == 0) begin
                    if (n < outpix) begin
                        e.addr = n;
                        e.data = (bpp == 2) ? pix0[r][c] * 256 + pix1[r][c] : pix0[r][c];
                        if (to_b) qb.push_back(e);
                        else qa.push_back(e);
                    end
                    n++;
                end
    endtask

    // One camera frame; pclk = clk_100/4, inputs change on the falling edge.
    task automatic send_frame(input int nrows, input int bpp);
        cmos_vsync = 1'b1;
        cmos_href  = 1'b0;
        cmos_pclk  = 1'b0;
        repeat ($urandom_range(4, 12)) @(negedge clk_100);
        cmos_vsync = 1'b0;
        repeat ($urandom_range(4, 10)) @(negedge clk_100);
        for (int r = 0; r < nrows; r++) begin
            cmos_href = 1'b1;
            for (int c = 0; c < H; c++)
                for (int b = 0; b < bpp; b++) begin
                    cmos_db   = 8'((b == 0) ? pix0[r][c] : pix1[r][c]);
                    cmos_pclk = 1'b0;
                    repeat (2) @(negedge clk_100);
                    cmos_pclk = 1'b1;
                    repeat (2) @(negedge clk_100);
                end
            cmos_pclk = 1'b0;
            cmos_href = 1'b0;
            repeat ($urandom_range(2, 5)) begin
                cmos_pclk = 1'b0;
                repeat (2) @(negedge clk_100);
                cmos_pclk = 1'b1;
                repeat (2) @(negedge clk_100);
            end
            cmos_pclk = 1'b0;
        end
        cmos_vsync = 1'b1;
        repeat (10) @(negedge clk_100);
    endtask

    task automatic pulse_arm(input bit to_b, input bit c);
        @(negedge clk_100);
        if (to_b) begin arm_b = 1'b1; cont_b = c; end
        else begin arm_a = 1'b1; cont_a = c; end
        @(negedge clk_100);
        arm_a = 1'b0;
        arm_b = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_100);
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        repeat (2) @(negedge clk_100);
        rst_n = 1'b1;
    endtask

    task automatic wait_log_a(input int k, input string nm);
        int t = 0;
        while (log_a.size() < k && t < 4000) begin
            @(negedge clk_100);
            t++;
        end
        chk(nm, 64'(log_a.size() >= k), 64'd1);
    endtask

    // Compare process: every cycle, each DUT write must match the next model entry,
    // and frame_done must follow exactly one cycle after the final-address write.
    initial begin : compare
        wr_t e;
        bit  dexp_a = 1'b0, dexp_b = 1'b0;
        forever begin
            @(posedge clk_100);
            #1;
            cyc++;
            chk("frame_done_a", frame_done_a, dexp_a);
            chk("frame_done_b", frame_done_b, dexp_b);
            dexp_a = 1'b0;
            dexp_b = 1'b0;
            if (wr_en_a) begin
                if (qa.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL write_a: got write addr=%0d data=%h, required no write", wr_addr_a, wr_data_a);
                end else begin
                    e = qa.pop_front();
                    chk("wr_addr_a", wr_addr_a, e.addr);
                    chk("wr_data_a", wr_data_a, e.data);
                    if (e.addr == 3) dexp_a = 1'b1;
                end
                log_a.push_back(int'(wr_data_a));
                lastwr_cyc_a = cyc;
            end
            if (wr_en_b) begin
                if (qb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL write_b: got write addr=%0d data=%h, required no write", wr_addr_b, wr_data_b);
                end else begin
                    e = qb.pop_front();
                    chk("wr_addr_b", wr_addr_b, e.addr);
                    chk("wr_data_b", wr_data_b, e.data);
                    if (e.addr == 15) dexp_b = 1'b1;
                end
                log_b.push_back(int'(wr_data_b));
            end
            if (frame_done_a) begin n_done_a++; done_cyc_a = cyc; end
            if (frame_err_a) n_errp_a++;
            if (frame_done_b) n_done_b++;
            if (frame_err_b) n_errp_b++;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base, bd, be;

        // Reset state
        repeat (3) @(negedge clk_100);
        chk("rst_wr_en", wr_en_a, 0);
        chk("rst_wr_addr", wr_addr_a, 0);
        chk("rst_wr_data", wr_data_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_frame_err", frame_err_a, 0);
        chk("rst_frame_cnt", frame_cnt_a, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_100);

        // Snapshot
        fill_pattern(2);
        base = log_a.size(); bd = n_done_a; be = n_errp_a;
        pulse_arm(1'b0, 1'b0);
        chk("snap_busy_armed", busy_a, 1);
        model_frame(V, 2, 2, 4, 1'b0);
        send_frame(V, 2);
        chk("snap_pending", qa.size(), 0);
        chk("snap_nwrites", log_a.size() - base, 4);
        if (log_a.size() >= base + 4) begin
            chk("snap_w0", log_a[base + 0], 16'h0102);
            chk("snap_w1", log_a[base + 1], 16'h0104);
            chk("snap_w2", log_a[base + 2], 16'h0302);
            chk("snap_w3", log_a[base + 3], 16'h0304);
        end
        chk("snap_done_lat", done_cyc_a, lastwr_cyc_a + 1);
        chk("snap_ndone", n_done_a - bd, 1);
        chk("snap_nerr", n_errp_a - be, 0);
        chk("snap_frame_cnt", frame_cnt_a, 1);
        chk("snap_busy_after", busy_a, 0);

        // Arm during WAIT_VS, then reset mid-frame
        pulse_arm(1'b0, 1'b0);
        pulse_arm(1'b0, 1'b1);
        chk("rst5_busy_wait", busy_a, 1);
        model_frame(V, 2, 2, 4, 1'b0);
        base = log_a.size();
        fork
            send_frame(V, 2);
            begin
                wait_log_a(base + 1, "rst5_first_write");
                @(negedge clk_100);
                rst_n = 1'b0;
                qa.delete();
                #1;
                chk("rst5_wr_en", wr_en_a, 0);
                chk("rst5_wr_addr", wr_addr_a, 0);
                chk("rst5_wr_data", wr_data_a, 0);
                chk("rst5_busy", busy_a, 0);
                chk("rst5_frame_done", frame_done_a, 0);
                chk("rst5_frame_err", frame_err_a, 0);
                chk("rst5_frame_cnt", frame_cnt_a, 0);
                repeat (3) @(negedge clk_100);
                rst_n = 1'b1;
            end
        join
        chk("rst5_busy_post", busy_a, 0);
        base = log_a.size();
        send_frame(V, 2);
        chk("rst5_no_arm_writes", log_a.size() - base, 0);
        chk("rst5_idle", busy_a, 0);
        pulse_arm(1'b0, 1'b0);
        model_frame(V, 2, 2, 4, 1'b0);
        send_frame(V, 2);
        chk("rst5_rearm_pending", qa.size(), 0);
        chk("rst5_rearm_nwrites", log_a.size() - base, 4);
        chk("rst5_rearm_cnt", frame_cnt_a, 1);

        // Continuous, 3 frames
        do_reset();
        base = log_a.size(); bd = n_done_a;
        pulse_arm(1'b0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            model_frame(V, 2, 2, 4, 1'b0);
            send_frame(V, 2);
        end
        chk("cont_pending", qa.size(), 0);
        chk("cont_nwrites", log_a.size() - base, 12);
        chk("cont_ndone", n_done_a - bd, 3);
        chk("cont_frame_cnt", frame_cnt_a, 3);
        chk("cont_busy", busy_a, 1);
        @(negedge clk_100); abort_a = 1'b1;
        @(negedge clk_100); abort_a = 1'b0;
        chk("cont_abort_busy", busy_a, 0);

        // Short frame
        do_reset();
        base = log_a.size(); bd = n_done_a; be = n_errp_a;
        pulse_arm(1'b0, 1'b0);
        model_frame(3, 2, 2, 4, 1'b0);
        send_frame(3, 2);
        chk("short_pending", qa.size(), 0);
        chk("short_nwrites", log_a.size() - base, 2);
        chk("short_nerr", n_errp_a - be, 1);
        chk("short_ndone", n_done_a - bd, 0);
        chk("short_frame_cnt", frame_cnt_a, 0);
        chk("short_busy", busy_a, 0);

        // Abort after the first write
        do_reset();
        base = log_a.size(); bd = n_done_a; be = n_errp_a;
        pulse_arm(1'b0, 1'b0);
        model_frame(V, 2, 2, 4, 1'b0);
        fork
            send_frame(V, 2);
            begin
                wait_log_a(base + 1, "abort_first_write");
                @(negedge clk_100);
                abort_a = 1'b1;
                qa.delete();
                @(negedge clk_100);
                abort_a = 1'b0;
                chk("abort_busy", busy_a, 0);
            end
        join
        chk("abort_nwrites", log_a.size() - base, 1);
        chk("abort_ndone", n_done_a - bd, 0);
        chk("abort_nerr", n_errp_a - be, 0);
        chk("abort_frame_cnt", frame_cnt_a, 0);

        // 1-byte pixels, no decimation
        do_reset();
        base = log_b.size(); bd = n_done_b;
        fill_pattern(1);
        pulse_arm(1'b1, 1'b0);
        model_frame(V, 1, 1, 16, 1'b1);
        send_frame(V, 1);
        chk("b_pending", qb.size(), 0);
        chk("b_nwrites", log_b.size() - base, 16);
        if (log_b.size() >= base + 16) begin
            chk("b_w0", log_b[base + 0], 2);
            chk("b_w3", log_b[base + 3], 5);
            chk("b_w4", log_b[base + 4], 2);
            chk("b_w15", log_b[base + 15], 5);
        end
        chk("b_ndone", n_done_b - bd, 1);
        chk("b_frame_cnt", frame_cnt_b, 1);
        chk("b_busy", busy_b, 0);

        // Random content, continuous
        do_reset();
        base = log_a.size();
        pulse_arm(1'b0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            fill_random();
            model_frame(V, 2, 2, 4, 1'b0);
            send_frame(V, 2);
        end
        chk("rand_pending", qa.size(), 0);
        chk("rand_nwrites", log_a.size() - base, 12);
        chk("rand_frame_cnt", frame_cnt_a, 3);
        chk("rand_busy", busy_a, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
